// File: rtl/lab2_proc_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lab2_proc_muldiv_pkg
//  Description : Shared types for the iterative multiply/divide unit:
//                operation codes and controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package lab2_proc_muldiv_pkg;

  // Operation select carried on req_fn; codes 5..7 are reserved.
  typedef enum logic [2:0] {
    MD_MUL  = 3'd0,
    MD_DIV  = 3'd1,
    MD_DIVU = 3'd2,
    MD_REM  = 3'd3,
    MD_REMU = 3'd4
  } md_fn_e;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/lab2_proc_iter_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lab2_proc_iter_muldiv_ctrl
//  Description : Sequencer for the iterative mul/div unit. Accepts a request
//                in IDLE, issues NBITS step pulses, spends one more cycle
//                finalising the result, then holds the response until taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module lab2_proc_iter_muldiv_ctrl
  import lab2_proc_muldiv_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int CBITS = $clog2(NBITS) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic req_val,
  input  logic resp_rdy,
  output logic load,
  output logic step,
  output logic done_en,
  output logic req_rdy,
  output logic resp_val
);

  localparam logic [CBITS-1:0] LAST_STEP = CBITS'(NBITS);

  md_state_e        state_q, state_d;
  logic [CBITS-1:0] count_q, count_d;

  // State and step-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state and control strobes. The cycle after the last step is used to
  // apply sign fix-up / special-case overrides, giving NBITS+1 cycles latency.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    load     = 1'b0;
    step     = 1'b0;
    done_en  = 1'b0;
    req_rdy  = 1'b0;
    resp_val = 1'b0;
    case (state_q)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) begin
          load    = 1'b1;
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (count_q == LAST_STEP) begin
          done_en = 1'b1;
          state_d = DONE;
        end else begin
          step    = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        resp_val = 1'b1;
        if (resp_rdy) begin
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lab2_proc_iter_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : lab2_proc_iter_muldiv
//  Description : Iterative multiply/divide unit (RV32M mul/div/divu/rem/remu)
//                with val/rdy request and response interfaces. Shift-add
//                multiply and restoring divide, one step per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module lab2_proc_iter_muldiv
  import lab2_proc_muldiv_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int CBITS = $clog2(NBITS) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [2:0]       req_fn,
  input  logic [NBITS-1:0] req_a,
  input  logic [NBITS-1:0] req_b,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_result
);

  localparam logic [NBITS-1:0] MIN_VAL = {1'b1, {(NBITS-1){1'b0}}};

  logic load, step, done_en;

  lab2_proc_iter_muldiv_ctrl #(
    .NBITS (NBITS),
    .CBITS (CBITS)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .resp_rdy (resp_rdy),
    .load     (load),
    .step     (step),
    .done_en  (done_en),
    .req_rdy  (req_rdy),
    .resp_val (resp_val)
  );

  // acc: MUL product accumulator / DIV partial remainder.
  // opa: MUL multiplicand (shifts left) / DIV dividend shifting into quotient.
  // opb: MUL multiplier (shifts right) / DIV divisor magnitude.
  logic [2:0]       fn_q, fn_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic [NBITS-1:0] opa_q, opa_d;
  logic [NBITS-1:0] opb_q, opb_d;
  logic [NBITS-1:0] a_raw_q, a_raw_d;
  logic [NBITS-1:0] result_q, result_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             b_zero_q, b_zero_d;
  logic             ovf_q, ovf_d;

  logic             signed_op;
  logic [NBITS-1:0] a_mag, b_mag;
  logic [NBITS-1:0] mul_addend, mul_sum;
  logic [NBITS:0]   rem_sh, div_diff;

  // Operand magnitudes for signed division, and per-step arithmetic.
  always_comb begin
    signed_op  = (req_fn == MD_DIV) || (req_fn == MD_REM);
    a_mag      = (signed_op && req_a[NBITS-1]) ? (~req_a + 1'b1) : req_a;
    b_mag      = (signed_op && req_b[NBITS-1]) ? (~req_b + 1'b1) : req_b;
    mul_addend = opb_q[0] ? opa_q : '0;
    mul_sum    = acc_q + mul_addend;
    rem_sh     = {acc_q, opa_q[NBITS-1]};
    div_diff   = rem_sh - {1'b0, opb_q};
  end

  // Datapath next-state: load on accept, iterate on step, finalise on done.
  always_comb begin
    fn_d      = fn_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    a_raw_d   = a_raw_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    b_zero_d  = b_zero_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    if (load) begin
      fn_d      = req_fn;
      acc_d     = '0;
      opa_d     = a_mag;
      opb_d     = b_mag;
      a_raw_d   = req_a;
      quo_neg_d = signed_op && (req_a[NBITS-1] ^ req_b[NBITS-1]);
      rem_neg_d = signed_op && req_a[NBITS-1];
      b_zero_d  = (req_b == '0);
      ovf_d     = (req_a == MIN_VAL) && (&req_b);
    end else if (step) begin
      if (fn_q == MD_MUL) begin
        acc_d = mul_sum;
        opa_d = {opa_q[NBITS-2:0], 1'b0};
        opb_d = {1'b0, opb_q[NBITS-1:1]};
      end else if (!div_diff[NBITS]) begin
        acc_d = div_diff[NBITS-1:0];
        opa_d = {opa_q[NBITS-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[NBITS-1:0];
        opa_d = {opa_q[NBITS-2:0], 1'b0};
      end
    end else if (done_en) begin
      case (fn_q)
        MD_MUL:  result_d = acc_q;
        MD_DIV:  result_d = b_zero_q ? '1 : ovf_q ? a_raw_q :
                            quo_neg_q ? (~opa_q + 1'b1) : opa_q;
        MD_DIVU: result_d = b_zero_q ? '1 : opa_q;
        MD_REM:  result_d = b_zero_q ? a_raw_q : ovf_q ? '0 :
                            rem_neg_q ? (~acc_q + 1'b1) : acc_q;
        MD_REMU: result_d = b_zero_q ? a_raw_q : acc_q;
        default: result_d = '0;
      endcase
    end
  end

  // Datapath registers; reset clears everything including the visible result.
  always_ff @(posedge clk) begin
    if (reset) begin
      fn_q      <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      a_raw_q   <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      fn_q      <= fn_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      a_raw_q   <= a_raw_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      b_zero_q  <= b_zero_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
    end
  end

  assign resp_result = result_q;

endmodule
`default_nettype wire
